// File: rtl/aes_out_collector.sv
// Result collector behind aes_engine: credit-tracks issued jobs, queues completed
// blocks in order with a sequence tag, and flags overflow/underflow events.
package aes_pkg;
    typedef enum logic [1:0] {
        INVALID = 2'd0,
        ENCRYPT = 2'd1,
        DECRYPT = 2'd2
    } job_t;
endpackage

module aes_out_collector #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  aes_pkg::job_t              issue_type,
    input  logic [127:0]               eng_out,
    input  aes_pkg::job_t              eng_out_type,
    output logic                       stall,
    output logic                       res_valid,
    output logic [127:0]               res_data,
    output aes_pkg::job_t              res_type,
    output logic [SEQ_W-1:0]           res_seq,
    input  logic                       res_ready,
    input  logic                       clr_err,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [127:0]     mem_data [DEPTH];
    logic [1:0]       mem_type [DEPTH];
    logic [SEQ_W-1:0] mem_seq  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq_cnt;
    logic [LW-1:0]    inflight;

    logic issue;
    logic comp;
    logic pop;
    logic push_acc;
    logic drop;
    logic unf_evt;

    always_comb begin
        issue    = (issue_type != aes_pkg::INVALID);
        comp     = (eng_out_type != aes_pkg::INVALID);
        pop      = res_valid && res_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push_acc = comp && ((level != FULL) || pop);
        drop     = comp && !push_acc;
        unf_evt  = comp && !issue && (inflight == '0);
    end

    // Head is read from registered storage so a push is never visible before the next cycle.
    always_comb begin
        res_valid = (level != '0);
        res_data  = '0;
        res_type  = aes_pkg::INVALID;
        res_seq   = '0;
        if (res_valid) begin
            res_data = mem_data[rd_ptr];
            res_type = aes_pkg::job_t'(mem_type[rd_ptr]);
            res_seq  = mem_seq[rd_ptr];
        end
    end

    always_comb begin
        stall = ({1'b0, level} + {1'b0, inflight}) >= {1'b0, FULL};
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_data[wr_ptr] <= eng_out;
            mem_type[wr_ptr] <= eng_out_type;
            mem_seq[wr_ptr]  <= seq_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            seq_cnt <= '0;
            level   <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr  <= wr_ptr + AW'(1);
                seq_cnt <= seq_cnt + SEQ_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_acc, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Dropped completions still return credit; issue and completion on one edge cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (issue && !comp) begin
            if (inflight != FULL) begin
                inflight <= inflight + LW'(1);
            end
        end else if (comp && !issue) begin
            if (inflight != '0) begin
                inflight <= inflight - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= drop    || (overflow  && !clr_err);
            underflow <= unf_evt || (underflow && !clr_err);
        end
    end
endmodule

// File: tb/tb_aes_out_collector.sv
// Randomised scoreboard bench for aes_out_collector with a queue-based reference model.
module tb_aes_out_collector;
    import aes_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk;
    logic          rst_n;
    job_t          issue_type;
    logic [127:0]  eng_out;
    job_t          eng_out_type;
    logic          stall;
    logic          res_valid;
    logic [127:0]  res_data;
    job_t          res_type;
    logic [7:0]    res_seq;
    logic          res_ready;
    logic          clr_err;
    logic          overflow;
    logic          underflow;
    logic [LW-1:0] level;

    aes_out_collector #(.DEPTH(DEPTH), .SEQ_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .issue_type(issue_type), .eng_out(eng_out),
        .eng_out_type(eng_out_type), .stall(stall), .res_valid(res_valid),
        .res_data(res_data), .res_type(res_type), .res_seq(res_seq),
        .res_ready(res_ready), .clr_err(clr_err), .overflow(overflow),
        .underflow(underflow), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        job_t         t;
        logic [7:0]   s;
    } exp_t;

    exp_t exp_q[$];
    int   m_level;
    int   m_infl;
    int   m_seq;
    bit   m_ovf;
    bit   m_unf;
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 0;
        m_infl  = 0;
        m_seq   = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Reference model: what the collector should hold after each rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            bit is_issue, is_comp, do_pop, accept, ovf_evt, unf_evt;
            exp_t e;
            is_issue = (issue_type != INVALID);
            is_comp  = (eng_out_type != INVALID);
            do_pop   = (m_level > 0) && res_ready;
            accept   = is_comp && ((m_level < DEPTH) || do_pop);
            ovf_evt  = is_comp && !accept;
            unf_evt  = 1'b0;
            if (accept) begin
                e.d = eng_out;
                e.t = eng_out_type;
                e.s = 8'(m_seq);
                exp_q.push_back(e);
                m_seq = (m_seq + 1) % 256;
            end
            m_level = m_level + (accept ? 1 : 0) - (do_pop ? 1 : 0);
            if (is_issue && !is_comp) begin
                m_infl = (m_infl + 1 > DEPTH) ? DEPTH : m_infl + 1;
            end else if (is_comp && !is_issue) begin
                if (m_infl == 0) unf_evt = 1'b1;
                else m_infl = m_infl - 1;
            end
            m_ovf = ovf_evt || (m_ovf && !clr_err);
            m_unf = unf_evt || (m_unf && !clr_err);
        end
    end

    // Monitor: compares status every cycle and the head on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("res_valid", 128'(res_valid), 128'(m_level != 0));
            chk("level", 128'(level), 128'(m_level));
            chk("stall", 128'(stall), 128'((m_level + m_infl) >= DEPTH));
            chk("overflow", 128'(overflow), 128'(m_ovf));
            chk("underflow", 128'(underflow), 128'(m_unf));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL head_unexpected actual=valid required=empty");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e.d);
                    chk("res_type", 128'(res_type), 128'(e.t));
                    chk("res_seq", 128'(res_seq), 128'(e.s));
                end
            end
        end
    end

    task automatic step(input job_t it, input job_t et, input logic [127:0] d,
                        input bit rdy, input bit clr);
        issue_type   = it;
        eng_out_type = et;
        eng_out      = d;
        res_ready    = rdy;
        clr_err      = clr;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic job_t rnd_type();
        return ($urandom_range(0, 1) == 0) ? ENCRYPT : DECRYPT;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 128'(res_valid), 128'(0));
        chk({tag, "_level"}, 128'(level), 128'(0));
        chk({tag, "_stall"}, 128'(stall), 128'(0));
        chk({tag, "_ovf"}, 128'(overflow), 128'(0));
        chk({tag, "_unf"}, 128'(underflow), 128'(0));
        chk({tag, "_data"}, res_data, 128'(0));
        chk({tag, "_type"}, 128'(res_type), 128'(INVALID));
        chk({tag, "_seq"}, 128'(res_seq), 128'(0));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        reset_checks(tag);
        model_clear();
        issue_type   = INVALID;
        eng_out_type = INVALID;
        eng_out      = '0;
        res_ready    = 1'b0;
        clr_err      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        issue_type   = INVALID;
        eng_out_type = INVALID;
        eng_out      = '0;
        res_ready    = 1'b0;
        clr_err      = 1'b0;
        rst_n        = 1'b0;
        #1;
        reset_checks("por");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // FIPS-197 vector: engine result supplied as the known ciphertext.
        step(ENCRYPT, INVALID, '0, 1'b1, 1'b0);
        repeat (3) step(INVALID, INVALID, '0, 1'b1, 1'b0);
        step(INVALID, ENCRYPT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1'b0);
        chk("fips_data", res_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("fips_type", 128'(res_type), 128'(ENCRYPT));
        chk("fips_seq", 128'(res_seq), 128'(0));
        repeat (3) step(INVALID, INVALID, '0, 1'b1, 1'b0);

        // Fill to capacity with res_ready low.
        do_reset("rst_fill");
        repeat (15) step(ENCRYPT, INVALID, '0, 1'b0, 1'b0);
        chk("stall_15", 128'(stall), 128'(0));
        step(ENCRYPT, INVALID, '0, 1'b0, 1'b0);
        chk("stall_16", 128'(stall), 128'(1));
        for (int i = 0; i < 16; i++) step(INVALID, rnd_type(), rnd128(), 1'b0, 1'b0);
        chk("full_level", 128'(level), 128'(16));
        chk("full_ovf", 128'(overflow), 128'(0));
        chk("full_head", 128'(res_seq), 128'(0));

        // Push and pop on the same edge while full.
        step(ENCRYPT, ENCRYPT, rnd128(), 1'b1, 1'b0);
        chk("pp_level", 128'(level), 128'(16));
        chk("pp_ovf", 128'(overflow), 128'(0));
        chk("pp_head", 128'(res_seq), 128'(1));

        // Drop while full, then clear.
        step(ENCRYPT, ENCRYPT, rnd128(), 1'b0, 1'b0);
        chk("drop_ovf", 128'(overflow), 128'(1));
        chk("drop_level", 128'(level), 128'(16));
        step(INVALID, INVALID, '0, 1'b0, 1'b1);
        chk("clr_ovf", 128'(overflow), 128'(0));
        repeat (18) step(INVALID, INVALID, '0, 1'b1, 1'b0);
        chk("drain_level", 128'(level), 128'(0));

        // Completion with nothing in flight, then sequence wrap.
        step(INVALID, DECRYPT, rnd128(), 1'b0, 1'b0);
        chk("unf_flag", 128'(underflow), 128'(1));
        chk("unf_level", 128'(level), 128'(1));
        chk("unf_seq", 128'(res_seq), 128'(17));
        for (int i = 0; i < 256; i++) step(INVALID, rnd_type(), rnd128(), 1'b1, 1'b0);
        repeat (3) step(INVALID, INVALID, '0, 1'b1, 1'b1);
        chk("wrap_unf_clr", 128'(underflow), 128'(0));

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            job_t it, et;
            it = INVALID;
            et = INVALID;
            if ($urandom_range(0, 9) < 3 && (!stall || $urandom_range(0, 7) == 0)) it = rnd_type();
            if ($urandom_range(0, 9) < 4) et = rnd_type();
            step(it, et, rnd128(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Reset with results queued and jobs in flight.
        do_reset("rst_mid0");
        repeat (8) step(ENCRYPT, INVALID, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(INVALID, rnd_type(), rnd128(), 1'b0, 1'b0);
        chk("mid_level", 128'(level), 128'(5));
        do_reset("rst_mid");
        step(INVALID, ENCRYPT, rnd128(), 1'b1, 1'b0);
        chk("post_unf", 128'(underflow), 128'(1));
        chk("post_seq", 128'(res_seq), 128'(0));
        repeat (4) step(INVALID, INVALID, '0, 1'b1, 1'b0);
        chk("post_drain", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_out_collector.md
AES_OUT_COLLECTOR -- requirements
Module: aes_out_collector

Interface
REQ-001 Parameter DEPTH, default 16, result FIFO entries (power of two, 4..64).
REQ-002 Parameter SEQ_W, default 8, width of result sequence tag.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 issue_type  input  job_t  job type presented to aes_engine in_type this cycle; ENCRYPT/DECRYPT = issue, INVALID = idle.
REQ-006 eng_out  input  128  aes_engine out.
REQ-007 eng_out_type  input  job_t  aes_engine out_type; ENCRYPT/DECRYPT = completed result, INVALID = bubble.
REQ-008 stall  output  1  credit exhausted; dispatcher SHALL NOT issue while high.
REQ-009 res_valid  output  1  FIFO head valid.
REQ-010 res_data  output  128  head result block.
REQ-011 res_type  output  job_t  head result type.
REQ-012 res_seq  output  SEQ_W  head sequence tag.
REQ-013 res_ready  input  1  consumer accepts head when high with res_valid.
REQ-014 clr_err  input  1  clears sticky error flags.
REQ-015 overflow  output  1  sticky: result dropped, FIFO full.
REQ-016 underflow  output  1  sticky: completion seen with zero jobs in flight.
REQ-017 level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 Push = eng_out_type is ENCRYPT or DECRYPT at a rising edge; pop = res_valid and res_ready.
REQ-019 Push writes {eng_out, eng_out_type, seq_cnt}; seq_cnt increments by 1 per accepted push, wraps 2^SEQ_W-1 -> 0.
REQ-020 Pushed entry visible on res_* the cycle after the push edge; no combinational fall-through.
REQ-021 res_data/res_type/res_seq hold stable while res_valid high and res_ready low.
REQ-022 Results leave strictly in push order.
REQ-023 Push with level==DEPTH accepted only if pop occurs same edge; otherwise result dropped, overflow set, seq_cnt not incremented.
REQ-024 Pop with level==0 impossible (res_valid low); res_ready ignored.
REQ-025 Simultaneous push and pop: level unchanged.
REQ-026 inflight counter: +1 on issue edge (issue_type != INVALID), -1 on push edge (including dropped pushes); both same edge: unchanged.
REQ-027 Completion with inflight==0 (and no same-edge issue): inflight stays 0, underflow set, result still pushed per REQ-023.
REQ-028 Issue while stall high still counted; inflight saturates at DEPTH, no wrap.
REQ-029 stall = (level + inflight >= DEPTH), combinational from registered state only; no combinational path from any input.
REQ-030 clr_err clears overflow and underflow at next edge; same-edge new error event wins (flag stays set).
REQ-031 Counter width rules: level and inflight $clog2(DEPTH)+1 bits, never exceed DEPTH.

Reset
REQ-032 rst_n low asynchronously sets: level=0, inflight=0, seq_cnt=0, FIFO pointers=0, res_valid=0, res_data=0, res_type=INVALID, res_seq=0, stall=0, overflow=0, underflow=0.
REQ-033 Reset mid-operation discards all FIFO contents and in-flight credit; results arriving after release are counted per REQ-027.
REQ-034 Outputs drive reset values from reset assertion through first edge after rst_n rises.

Verification
REQ-035 FIPS-197 path: key 000102030405060708090a0b0c0d0e0f, issue ENCRYPT 00112233445566778899aabbccddeeff via aes_engine, res_ready=1 -> one result 69c4e0d86a7b0430d8cdb78070b4c55a, res_type ENCRYPT, res_seq 0.
REQ-036 DEPTH=16, res_ready=0, issue back-to-back -> stall rises after 16 issues; exactly 16 results queued, level=16, overflow=0, res_seq 0..15 in order.
REQ-037 Full FIFO, res_ready=1 for one cycle coincident with push -> level stays 16, no overflow, head advances to seq 1.
REQ-038 Full FIFO, res_ready=0, force extra eng_out_type=ENCRYPT -> overflow=1, level=16, seq_cnt unchanged; clr_err pulse -> overflow=0.
REQ-039 Drive eng_out_type=DECRYPT with no prior issue -> underflow=1, inflight=0, entry queued; 256 pushes -> res_seq wraps 255 -> 0.
REQ-040 Assert rst_n low with 5 queued, 3 in flight -> res_valid=0, level=0, stall=0 immediately (before next edge).
